nbit_and_nand_nor_unit: RTL and testbench
=========================================

// Module: nbit_and_nand_nor_unit
// PURPOSE
// - Registered n-bit bitwise logic unit: per-bit AND, NAND or NOR of two WIDTH-bit operands, chosen by op select.
// - Sits in the ALU logic path beside the combinational n-bit gate wrappers.
// - Adds a one-cycle pipeline register, valid tracking, zero/all-ones flags and an illegal-op flag.
// PARAMETERS
// - WIDTH  default 4  operand/result bit width; legal range 1..64.
//   - Out of range is an elaboration-time $error.
// PORTS
// - clk        in   1      single clock; all state updates on rising edge
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      operands/op valid this cycle
// - op         in   2      00=AND, 01=NAND, 10=NOR, 11=illegal
// - in1        in   WIDTH  operand A
// - in2        in   WIDTH  operand B
// - out_valid  out  1      out/flags hold a result captured last cycle
// - out        out  WIDTH  registered result
// - zero       out  1      registered: out == 0
// - ones       out  1      registered: out == all ones
// - op_err     out  1      registered: captured op was 11
// BEHAVIOUR
// - Reset, sampled on rising clk while rst=1:
//   - out_valid=0, out=0, zero=0, ones=0, op_err=0.
//   - rst has priority over in_valid in the same cycle.
//   - Mid-stream reset discards any result being captured.
// - Per-bit function, for each i in 0..WIDTH-1:
//   - AND:  out[i] = in1[i] & in2[i]
//   - NAND: out[i] = ~(in1[i] & in2[i])
//   - NOR:  out[i] = ~(in1[i] | in2[i])
//   - No carries or cross-bit interaction; result width = WIDTH exactly.
// - Latency: 1 cycle. in_valid=1 at edge N -> out_valid=1 and result visible after edge N.
//   - Throughput 1 op/cycle; no backpressure (no ready signal).
// - in_valid=0 at an edge:
//   - out_valid<=0.
//   - out, zero, ones, op_err hold their previous values.
// - op=11 with in_valid=1:
//   - out<=0, op_err<=1, zero<=1, ones<=0, out_valid<=1.
// - Legal op with in_valid=1: op_err<=0; zero/ones computed from the new result.
// - WIDTH=1: zero and ones are mutually exclusive complements of out on legal ops.
// - X on in1/in2 while in_valid=0 must not disturb held outputs.
// - Fully synchronous: no latches, no combinational input->output path.
// TESTING (WIDTH=4 unless stated)
// - Reset: assert rst 2 cycles with in_valid=1, op=00, in1=in2=1111
//   -> out_valid=0, out=0000, flags 0 throughout.
// - Truth sweep: in1=1100, in2=1010
//   -> AND out=1000; NAND out=0111; NOR out=0001.
//   - Each appears 1 cycle after issue, out_valid=1.
// - Flags: AND 0000&1111 -> zero=1, ones=0; NAND 0000,0000 -> out=1111, ones=1; NOR 1111,0000 -> out=0000, zero=1.
// - Back-to-back: issue AND, NAND, NOR on consecutive cycles, in1=0110, in2=0011
//   -> out 0010, 1101, 1000 on consecutive cycles; out_valid stays 1.
// - Illegal op / hold: op=11 -> out=0000, op_err=1, zero=1.
//   - Then in_valid=0 -> out_valid=0, out/op_err held.
//   - Then legal op -> op_err=0.
// - Exhaustive: WIDTH=1 and WIDTH=8, all input pairs x 3 ops vs reference model.
//   - Include rst asserted mid-stream -> next cycle out_valid=0, out=0.

Source files
------------

// File: rtl/nbit_and_nand_nor_unit.sv
// Registered n-bit bitwise logic unit.
// Computes a per-bit AND, NAND or NOR of two WIDTH-bit operands. The result
// appears one cycle after issue, together with zero/all-ones flags and an
// illegal-op flag. When no new operand is accepted, the result and flags hold
// their values, and only the valid bit drops.
module nbit_and_nand_nor_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ones,
  output logic             op_err
);

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_NAND = 2'b01,
    OP_NOR  = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  // Reject widths outside 1..64 when the design is elaborated.
  if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
    $error("nbit_and_nand_nor_unit: WIDTH=%0d outside legal range 1..64", WIDTH);
  end

  // Per-bit gate outputs. No bit depends on any other bit.
  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] nand_bits;
  logic [WIDTH-1:0] nor_bits;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign and_bits[gi]  = in1[gi] & in2[gi];
    assign nand_bits[gi] = ~(in1[gi] & in2[gi]);
    assign nor_bits[gi]  = ~(in1[gi] | in2[gi]);
  end

  // Next-state values. They are captured only when in_valid is high.
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic             ones_d;
  logic             err_d;

  // Select the gate output for the op. An illegal op yields zero and raises err.
  always_comb begin
    result_d = '0;
    err_d    = 1'b0;
    case (op_e'(op))
      OP_AND:  result_d = and_bits;
      OP_NAND: result_d = nand_bits;
      OP_NOR:  result_d = nor_bits;
      default: err_d    = 1'b1;
    endcase
    // An illegal op leaves result_d at zero, so zero=1 and ones=0 for it.
    zero_d = (result_d == '0);
    ones_d = &result_d;
  end

  // Pipeline registers.
  logic             valid_q;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             ones_q;
  logic             err_q;

  // Capture on valid input. Otherwise drop valid and hold the payload.
  // Reset wins over everything, including an in-flight capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      ones_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        out_q  <= result_d;
        zero_q <= zero_d;
        ones_q <= ones_d;
        err_q  <= err_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign ones      = ones_q;
  assign op_err    = err_q;

endmodule

// File: tb/tb_nbit_and_nand_nor_unit.sv
// Directed and exhaustive checks for nbit_and_nand_nor_unit at WIDTH 4, 1 and 8.
module tb_nbit_and_nand_nor_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- WIDTH=4 instance ----------------
  logic       v4;
  logic [1:0] op4;
  logic [3:0] a4, b4;
  logic       ov4, z4, on4, e4;
  logic [3:0] o4;

  nbit_and_nand_nor_unit #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .op(op4), .in1(a4), .in2(b4),
    .out_valid(ov4), .out(o4), .zero(z4), .ones(on4), .op_err(e4)
  );

  // ---------------- WIDTH=1 instance ----------------
  logic       v1;
  logic [1:0] op1;
  logic       a1, b1;
  logic       ov1, z1, on1, e1, o1;

  nbit_and_nand_nor_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .op(op1), .in1(a1), .in2(b1),
    .out_valid(ov1), .out(o1), .zero(z1), .ones(on1), .op_err(e1)
  );

  // ---------------- WIDTH=8 instances ----------------
  // Six copies: the three ops times two halves of the in1 space.
  // Together they cover all 8-bit pairs in 32768 cycles.
  logic       v8;
  logic [1:0] op8 [6];
  logic [7:0] a8  [6];
  logic [7:0] b8  [6];
  logic       ov8 [6];
  logic       z8  [6];
  logic       on8 [6];
  logic       e8  [6];
  logic [7:0] o8  [6];

  for (genvar gi = 0; gi < 6; gi++) begin : g_w8
    nbit_and_nand_nor_unit #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(v8), .op(op8[gi]), .in1(a8[gi]), .in2(b8[gi]),
      .out_valid(ov8[gi]), .out(o8[gi]), .zero(z8[gi]), .ones(on8[gi]), .op_err(e8[gi])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] a,
                                       input logic [7:0] b, input int w);
    logic [7:0] m;
    logic [7:0] r;
    m = (w >= 8) ? 8'hFF : 8'((9'h1 << w) - 9'h1);
    case (o)
      2'b00:   r = a & b;
      2'b01:   r = ~(a & b);
      2'b10:   r = ~(a | b);
      default: r = 8'h00;
    endcase
    return r & m;
  endfunction

  // Drive one W4 operation and step to just after the capturing edge.
  task automatic issue4(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    v4 = 1'b1; op4 = o; a4 = a; b4 = b;
    @(posedge clk); #1;
  endtask

  // Packed W4 observation: {out_valid, out, zero, ones, op_err}.
  function automatic logic [7:0] obs4();
    return {ov4, o4, z4, on4, e4};
  endfunction

  initial begin
    logic [7:0] exp8;
    logic [1:0] o;
    rst = 1'b1;
    v4 = 1'b1; op4 = 2'b00; a4 = 4'hF; b4 = 4'hF;
    v1 = 1'b0; op1 = 2'b00; a1 = 1'b0; b1 = 1'b0;
    v8 = 1'b0;
    for (int g = 0; g < 6; g++) begin
      op8[g] = 2'(g % 3); a8[g] = 8'h00; b8[g] = 8'h00;
    end

    // Reset for two cycles with a valid AND of 1111&1111 pending.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check($sformatf("reset_c%0d", c), 64'(obs4()), 64'h00);
    end
    check("reset_w1", 64'({ov1, o1, z1, on1, e1}), 64'h0);
    rst = 1'b0;

    // Truth sweep on 1100 / 1010.
    issue4(2'b00, 4'b1100, 4'b1010); check("truth_and",  64'(obs4()), 64'({1'b1, 4'b1000, 3'b000}));
    issue4(2'b01, 4'b1100, 4'b1010); check("truth_nand", 64'(obs4()), 64'({1'b1, 4'b0111, 3'b000}));
    issue4(2'b10, 4'b1100, 4'b1010); check("truth_nor",  64'(obs4()), 64'({1'b1, 4'b0001, 3'b000}));

    // Flag cases.
    issue4(2'b00, 4'b0000, 4'b1111); check("flag_and_zero",  64'(obs4()), 64'({1'b1, 4'b0000, 3'b100}));
    issue4(2'b01, 4'b0000, 4'b0000); check("flag_nand_ones", 64'(obs4()), 64'({1'b1, 4'b1111, 3'b010}));
    issue4(2'b10, 4'b1111, 4'b0000); check("flag_nor_zero",  64'(obs4()), 64'({1'b1, 4'b0000, 3'b100}));

    // Back-to-back on 0110 / 0011.
    issue4(2'b00, 4'b0110, 4'b0011); check("b2b_and",  64'(obs4()), 64'({1'b1, 4'b0010, 3'b000}));
    issue4(2'b01, 4'b0110, 4'b0011); check("b2b_nand", 64'(obs4()), 64'({1'b1, 4'b1101, 3'b000}));
    issue4(2'b10, 4'b0110, 4'b0011); check("b2b_nor",  64'(obs4()), 64'({1'b1, 4'b1000, 3'b000}));

    // Illegal op, then hold with X operands, then a legal op clears op_err.
    issue4(2'b11, 4'b1111, 4'b1111); check("illegal",  64'(obs4()), 64'({1'b1, 4'b0000, 3'b101}));
    v4 = 1'b0; op4 = 2'b00; a4 = 4'bxxxx; b4 = 4'bxxxx;
    @(posedge clk); #1;              check("hold_1",   64'(obs4()), 64'({1'b0, 4'b0000, 3'b101}));
    @(posedge clk); #1;              check("hold_2",   64'(obs4()), 64'({1'b0, 4'b0000, 3'b101}));
    issue4(2'b00, 4'b1111, 4'b1111); check("legal_clr", 64'(obs4()), 64'({1'b1, 4'b1111, 3'b010}));
    v4 = 1'b0;

    // WIDTH=1: every op and operand pair.
    for (int k = 0; k < 12; k++) begin
      o = 2'(k / 4);
      v1 = 1'b1; op1 = o; a1 = k[1]; b1 = k[0];
      @(posedge clk); #1;
      exp8 = model(o, {7'b0, k[1]}, {7'b0, k[0]}, 1);
      check($sformatf("w1_op%0d_a%0d_b%0d", o, k[1], k[0]),
            64'({ov1, o1, z1, on1, e1}), 64'({1'b1, exp8[0], ~exp8[0], exp8[0], 1'b0}));
    end
    issue4(2'b11, 4'b0, 4'b0); v4 = 1'b0;
    v1 = 1'b1; op1 = 2'b11; a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    check("w1_illegal", 64'({ov1, o1, z1, on1, e1}), 64'({1'b1, 1'b0, 1'b1, 1'b0, 1'b1}));
    v1 = 1'b0;

    // WIDTH=8: all pairs for all ops, with a reset pulse in the middle.
    for (int k = 0; k < 32768; k++) begin
      v8 = 1'b1;
      for (int g = 0; g < 6; g++) begin
        a8[g] = {1'(g / 3), k[14:8]};
        b8[g] = k[7:0];
      end
      if (k == 1000) begin
        rst = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < 6; g++)
          check($sformatf("w8_midrst_%0d", g), 64'({ov8[g], o8[g]}), 64'h0);
        rst = 1'b0;
      end
      @(posedge clk); #1;
      for (int g = 0; g < 6; g++) begin
        exp8 = model(op8[g], a8[g], b8[g], 8);
        check($sformatf("w8_op%0d_a%02h_b%02h", op8[g], a8[g], b8[g]),
              64'({ov8[g], z8[g], on8[g], e8[g], o8[g]}),
              64'({1'b1, exp8 == 8'h00, exp8 == 8'hFF, 1'b0, exp8}));
      end
    end
    v8 = 1'b0;
    @(posedge clk); #1;
    check("w8_idle_valid", 64'(ov8[0]), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
